discharge_param_bank: RTL
=========================

Name: discharge_param_bank

Overview:
- Next-generation run-gating and parameter-staging block in front of mos_control.
- Generalises the fixed two-source run gate to NUM_RUN_SRC sources plus a fault stop.
- Replaces the four fixed parameter channels with NUM_PARAMS indexed, range-clamped, double-buffered slots.
- While machining, staged values reach the pulse generator only at discharge-cycle boundaries, never mid-pulse.

Parameters:
- NUM_PARAMS, 4, number of parameter slots (index 0 Ton, 1 Toff, 2 Ip, 3 waveform).
- DATA_W, 16, width of each parameter.
- SEL_W, 3, width of the write-select field; must be at least clog2(NUM_PARAMS).
- NUM_RUN_SRC, 2, number of run sources (bit 0 SPI, bit 1 key).
- RUN_RESET_MASK, 2'b10, reset value of per-source run bits (key runs, SPI stopped).
- PARAM_RESET, {16'h0001,16'd20,16'd50,16'd10}, packed reset values, slot 0 in LSBs.
- PARAM_MIN, {16'h0000,16'd0,16'd1,16'd1}, packed per-slot lower clamp.
- PARAM_MAX, {16'h8002,16'd78,16'd1000,16'd500}, packed per-slot upper clamp.

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- run_start_ack  in  NUM_RUN_SRC  per-source start pulse
- run_stop_ack  in  NUM_RUN_SRC  per-source stop pulse
- fault_stop  in  1  clears all run bits
- param_wr_ack  in  1  single-cycle write strobe, synchronous to clk
- param_wr_sel  in  SEL_W  slot index, valid with param_wr_ack
- param_wr_data_async  in  DATA_W  write data, stable on the ack cycle
- cycle_boundary  in  1  one-cycle pulse from mos_control at the start of each discharge cycle
- err_clr  in  1  clears sticky error flags
- is_machine  out  1  AND of all run bits
- run_state  out  NUM_RUN_SRC  per-source run bits
- params_active  out  NUM_PARAMS*DATA_W  committed values driven to mos_control
- param_pending  out  NUM_PARAMS  per-slot shadow-not-yet-committed flag
- commit_pulse  out  1  one-cycle pulse on each commit
- range_err  out  1  sticky: a write was clamped
- sel_err  out  1  sticky: a write had an out-of-range select

Behaviour:
- Reset state:
  - run_state = RUN_RESET_MASK.
  - shadow = active = PARAM_RESET.
  - param_pending = 0.
  - commit_pulse, range_err, sel_err all 0.
- Run bit priority, per source, highest first: fault_stop clears it; then start sets it; then stop clears it; otherwise it holds. Start and stop in the same cycle therefore leaves the bit set.
- is_machine = &run_state (combinational from registers), so it asserts 1 cycle after the enabling ack.
- Write, when param_wr_ack=1 and sel < NUM_PARAMS:
  - shadow[sel] <= clamp(data, MIN[sel], MAX[sel]), compared unsigned.
  - pending[sel] <= 1.
  - If clamping occurred, range_err <= 1.
- Write with sel >= NUM_PARAMS: no slot changes; sel_err <= 1.
- Commit FSM has two states:
  - FREE (is_machine=0): any pending slot commits on the next edge (active <= shadow, pending cleared, commit_pulse=1). Write-to-active latency is 2 cycles.
  - LOCKED (is_machine=1): commit happens only on a cycle with cycle_boundary=1 and pending != 0. All pending slots commit atomically on that edge.
  - State follows is_machine registered. A cycle_boundary pulse while FREE has no extra effect.
- Write and commit in the same cycle: the commit uses the pre-write shadow, the new value lands in shadow, and pending[sel] stays 1 for the next commit.
- Non-pending slots never change active on a commit.
- fault_stop mid-operation: is_machine drops the next cycle, the FSM enters FREE, and pending values commit the following cycle.
- err_clr clears both sticky flags. If err_clr and a new error occur in the same cycle, the flag stays set.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronous).

Decomposition:
- Shared package discharge_pkg holds:
  - slot indices IDX_TON=0, IDX_TOFF=1, IDX_IP=2, IDX_WAVEFORM=3;
  - waveform codes WF_RES=16'h8000, WF_BUCK_RECT=16'h0001, WF_BUCK_TRI=16'h0002;
  - default reset/min/max constants.
- One sub-module, param_slot, instantiated NUM_PARAMS times by generate. It holds one slot's shadow, active, pending and clamp logic, with inputs wr_en, commit_en and data.

Test Plan:
- Reset release with no stimulus -> run_state=2'b10, is_machine=0, params_active equals PARAM_RESET, all flags 0.
- is_machine=0; write sel=0 data=200 -> pending[0]=1 for one cycle, then slot 0 active=200 two cycles after the ack, commit_pulse for one cycle.
- Start SPI (is_machine=1); write sel=2 data=100 -> shadow clamped to 78, range_err=1; active stays 20 until cycle_boundary, then becomes 78 on the next edge.
- is_machine=1; write sel=1 data=300 in the same cycle as cycle_boundary, with slot 0 already pending -> slot 0 commits, slot 1 stays pending and commits at the next boundary.
- Write sel=5 -> sel_err=1 and no slot changes. Then err_clr -> sel_err=0.
- Running with a pending slot, pulse fault_stop -> run_state=0 next cycle, pending commits the cycle after. Then a simultaneous start and stop on key -> key bit=1.

Source files
------------

// File: rtl/discharge_pkg.sv
// Shared constants for the discharge parameter bank: slot indices, waveform codes,
// default reset/clamp tables and the commit FSM state type.
package discharge_pkg;

  localparam int NUM_PARAMS_DEF  = 4;
  localparam int DATA_W_DEF      = 16;
  localparam int SEL_W_DEF       = 3;
  localparam int NUM_RUN_SRC_DEF = 2;

  localparam int IDX_TON      = 0;
  localparam int IDX_TOFF     = 1;
  localparam int IDX_IP       = 2;
  localparam int IDX_WAVEFORM = 3;

  localparam logic [15:0] WF_RES       = 16'h8000;
  localparam logic [15:0] WF_BUCK_RECT = 16'h0001;
  localparam logic [15:0] WF_BUCK_TRI  = 16'h0002;

  // Key source runs out of reset, SPI source stopped.
  localparam logic [1:0]  RUN_RESET_MASK_DEF = 2'b10;

  // Packed tables, slot 0 in the LSBs: {waveform, Ip, Toff, Ton}.
  localparam logic [63:0] PARAM_RESET_DEF = {WF_BUCK_RECT, 16'd20, 16'd50, 16'd10};
  localparam logic [63:0] PARAM_MIN_DEF   = {16'h0000, 16'd0, 16'd1, 16'd1};
  localparam logic [63:0] PARAM_MAX_DEF   = {16'h8002, 16'd78, 16'd1000, 16'd500};

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } commit_state_e;

endpackage

// File: rtl/discharge_param_bank_if.sv
// Control/status bundle between the host-side run/parameter logic and the parameter bank.
interface discharge_param_bank_if #(
  parameter int NUM_PARAMS  = 4,
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 3,
  parameter int NUM_RUN_SRC = 2
);
  logic [NUM_RUN_SRC-1:0]       run_start_ack;
  logic [NUM_RUN_SRC-1:0]       run_stop_ack;
  logic                         fault_stop;
  logic                         param_wr_ack;
  logic [SEL_W-1:0]             param_wr_sel;
  logic [DATA_W-1:0]            param_wr_data_async;
  logic                         cycle_boundary;
  logic                         err_clr;
  logic                         is_machine;
  logic [NUM_RUN_SRC-1:0]       run_state;
  logic [NUM_PARAMS*DATA_W-1:0] params_active;
  logic [NUM_PARAMS-1:0]        param_pending;
  logic                         commit_pulse;
  logic                         range_err;
  logic                         sel_err;

  modport master (
    output run_start_ack, run_stop_ack, fault_stop, param_wr_ack, param_wr_sel,
           param_wr_data_async, cycle_boundary, err_clr,
    input  is_machine, run_state, params_active, param_pending, commit_pulse,
           range_err, sel_err
  );

  modport slave (
    input  run_start_ack, run_stop_ack, fault_stop, param_wr_ack, param_wr_sel,
           param_wr_data_async, cycle_boundary, err_clr,
    output is_machine, run_state, params_active, param_pending, commit_pulse,
           range_err, sel_err
  );
endinterface

// File: rtl/discharge_param_bank_slot.sv
// One double-buffered parameter slot: clamped shadow register, committed active
// register and a pending flag marking shadow != active-to-be.
module param_slot #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter logic [DATA_W-1:0] MIN_VAL = '0,
  parameter logic [DATA_W-1:0] MAX_VAL = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              commit_en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] active,
  output logic              pending,
  output logic              clipped
);

  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] clamped;
  logic [DATA_W:0]   lo_diff;
  logic [DATA_W:0]   hi_diff;

  // Borrow-out of a widened subtract gives the unsigned compare without
  // tripping constant-compare lint when a bound is zero or all-ones.
  assign lo_diff = {1'b0, data} - {1'b0, MIN_VAL};
  assign hi_diff = {1'b0, MAX_VAL} - {1'b0, data};

  always_comb begin
    clamped = data;
    clipped = 1'b0;
    if (lo_diff[DATA_W]) begin
      clamped = MIN_VAL;
      clipped = wr_en;
    end else if (hi_diff[DATA_W]) begin
      clamped = MAX_VAL;
      clipped = wr_en;
    end
  end

  // Commit copies the pre-write shadow; a same-cycle write re-arms pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= RST_VAL;
      active  <= RST_VAL;
      pending <= 1'b0;
    end else begin
      if (commit_en && pending) active <= shadow;
      if (wr_en) shadow <= clamped;
      if (wr_en)          pending <= 1'b1;
      else if (commit_en) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/discharge_param_bank.sv
// Run gating plus indexed, clamped, double-buffered parameter staging in front of
// mos_control; staged values only reach the pulse generator at cycle boundaries while machining.
module discharge_param_bank
  import discharge_pkg::*;
#(
  parameter int                             NUM_PARAMS     = NUM_PARAMS_DEF,
  parameter int                             DATA_W         = DATA_W_DEF,
  parameter int                             SEL_W          = SEL_W_DEF,
  parameter int                             NUM_RUN_SRC    = NUM_RUN_SRC_DEF,
  parameter logic [NUM_RUN_SRC-1:0]         RUN_RESET_MASK = RUN_RESET_MASK_DEF,
  parameter logic [NUM_PARAMS*DATA_W-1:0]   PARAM_RESET    = PARAM_RESET_DEF,
  parameter logic [NUM_PARAMS*DATA_W-1:0]   PARAM_MIN      = PARAM_MIN_DEF,
  parameter logic [NUM_PARAMS*DATA_W-1:0]   PARAM_MAX      = PARAM_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  discharge_param_bank_if.slave  bus
);

  logic [NUM_RUN_SRC-1:0]             run_q, run_nxt;
  commit_state_e                      state_q, state_nxt;
  logic                               commit;
  logic                               commit_q, range_q, sel_q;
  logic                               wr_ok, sel_bad, range_hit;
  logic [NUM_PARAMS-1:0]              wr_en, pending, clipped;
  logic [NUM_PARAMS-1:0][DATA_W-1:0]  active;

  // Per-source priority: fault clears, start sets, stop clears, else hold.
  always_comb begin
    run_nxt = run_q;
    for (int i = 0; i < NUM_RUN_SRC; i++) begin
      if (bus.fault_stop)               run_nxt[i] = 1'b0;
      else if (bus.run_start_ack[i])    run_nxt[i] = 1'b1;
      else if (bus.run_stop_ack[i])     run_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= RUN_RESET_MASK;
    else        run_q <= run_nxt;
  end

  // FSM state tracks the registered AND of the run bits, so it always equals is_machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= (&RUN_RESET_MASK) ? ST_LOCKED : ST_FREE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = (&run_nxt) ? ST_LOCKED : ST_FREE;
    commit    = 1'b0;
    case (state_q)
      ST_FREE:   commit = |pending;
      ST_LOCKED: commit = bus.cycle_boundary && (|pending);
    endcase
  end

  // Write data is held stable by the host on the strobe cycle, so it is sampled directly.
  assign wr_ok   = bus.param_wr_ack && (32'(bus.param_wr_sel) < 32'(NUM_PARAMS));
  assign sel_bad = bus.param_wr_ack && !(32'(bus.param_wr_sel) < 32'(NUM_PARAMS));

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_slot
    assign wr_en[g] = wr_ok && (bus.param_wr_sel == SEL_W'(g));

    param_slot #(
      .DATA_W  (DATA_W),
      .RST_VAL (PARAM_RESET[g*DATA_W +: DATA_W]),
      .MIN_VAL (PARAM_MIN[g*DATA_W +: DATA_W]),
      .MAX_VAL (PARAM_MAX[g*DATA_W +: DATA_W])
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[g]),
      .commit_en (commit),
      .data      (bus.param_wr_data_async),
      .active    (active[g]),
      .pending   (pending[g]),
      .clipped   (clipped[g])
    );
  end

  assign range_hit = |clipped;

  // Sticky flags: a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q <= 1'b0;
      range_q  <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      commit_q <= commit;
      if (range_hit)        range_q <= 1'b1;
      else if (bus.err_clr) range_q <= 1'b0;
      if (sel_bad)          sel_q   <= 1'b1;
      else if (bus.err_clr) sel_q   <= 1'b0;
    end
  end

  assign bus.run_state     = run_q;
  assign bus.is_machine    = &run_q;
  assign bus.params_active = active;
  assign bus.param_pending = pending;
  assign bus.commit_pulse  = commit_q;
  assign bus.range_err     = range_q;
  assign bus.sel_err       = sel_q;

endmodule
